// File: rtl/sound_fx_if.sv
// Trigger and tone-output bundle between gameplay logic and the sound sequencer.
interface sound_fx_if;
  logic       trig_hit;
  logic       trig_pocket;
  logic       sound_enable;
  logic [9:0] tone_freq;
  logic       busy;
  logic       done;

  // Gameplay side: raises triggers, observes the tone channel.
  modport master (
    output trig_hit, trig_pocket,
    input  sound_enable, tone_freq, busy, done
  );

  // Sequencer side.
  modport slave (
    input  trig_hit, trig_pocket,
    output sound_enable, tone_freq, busy, done
  );
endinterface

// File: rtl/sound_fx_sequencer.sv
// Sound effect sequencer: plays the hit / pocket note sequences from a small
// ROM, timing each note and inter-note gap in ticks of TICK_CYCLES clocks.
// All outputs are registered; triggers only reach them through a flop.
module sound_fx_sequencer #(
  parameter int TICK_CYCLES = 50000,
  parameter int GAP_TICKS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  sound_fx_if.slave  bus
);

  localparam int              PW         = $clog2(TICK_CYCLES) + 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [7:0]      GAP_LAST   = (GAP_TICKS > 0) ? 8'(GAP_TICKS - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

  // Note ROM: frequency code for {effect, index}; effect 1 = pocket.
  function automatic logic [9:0] rom_freq(input logic pocket, input logic [1:0] idx);
    logic [9:0] f;
    f = 10'd0;
    case ({pocket, idx})
      3'b000:  f = 10'd523;
      3'b001:  f = 10'd659;
      3'b010:  f = 10'd784;
      3'b100:  f = 10'd784;
      3'b101:  f = 10'd659;
      3'b110:  f = 10'd523;
      3'b111:  f = 10'd392;
      default: f = 10'd0;
    endcase
    return f;
  endfunction

  // Note ROM: duration in ticks for {effect, index}.
  function automatic logic [7:0] rom_ticks(input logic pocket, input logic [1:0] idx);
    logic [7:0] t;
    t = 8'd1;
    case ({pocket, idx})
      3'b000:  t = 8'd30;
      3'b001:  t = 8'd30;
      3'b010:  t = 8'd60;
      3'b100:  t = 8'd40;
      3'b101:  t = 8'd40;
      3'b110:  t = 8'd40;
      3'b111:  t = 8'd120;
      default: t = 8'd1;
    endcase
    return t;
  endfunction

  state_t        r_state, w_state_nxt;
  logic          r_pocket, w_pocket_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_tick;
  logic          r_en, w_en_nxt;
  logic [9:0]    r_freq, w_freq_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          w_clr;

  logic          w_active, w_presc_end, w_note_end, w_gap_end;
  logic          w_go_pocket, w_go_hit, w_last;
  logic [1:0]    w_idx_inc;

  assign w_active    = (r_state != S_IDLE);
  assign w_presc_end = (r_presc == PRESC_LAST);
  assign w_note_end  = (r_state == S_NOTE) && w_presc_end &&
                       (r_tick == rom_ticks(r_pocket, r_idx) - 8'd1);
  assign w_gap_end   = (r_state == S_GAP) && w_presc_end && (r_tick == GAP_LAST);
  assign w_last      = (r_idx == (r_pocket ? 2'd3 : 2'd2));
  assign w_idx_inc   = r_idx + 2'd1;
  // Pocket always wins; a hit cannot interrupt a running pocket effect.
  assign w_go_pocket = bus.trig_pocket;
  assign w_go_hit    = bus.trig_hit && !bus.trig_pocket && !(w_active && r_pocket);

  // Next-state and next-output decode; a (re)start overrides any note/gap end.
  always_comb begin
    w_state_nxt  = r_state;
    w_pocket_nxt = r_pocket;
    w_idx_nxt    = r_idx;
    w_en_nxt     = r_en;
    w_freq_nxt   = r_freq;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_clr        = 1'b0;
    if (w_go_pocket || w_go_hit) begin
      w_state_nxt  = S_NOTE;
      w_pocket_nxt = w_go_pocket;
      w_idx_nxt    = 2'd0;
      w_en_nxt     = 1'b1;
      w_freq_nxt   = rom_freq(w_go_pocket, 2'd0);
      w_busy_nxt   = 1'b1;
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        S_NOTE: begin
          if (w_note_end) begin
            w_clr = 1'b1;
            if (w_last) begin
              w_state_nxt = S_IDLE;
              w_en_nxt    = 1'b0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else if (GAP_TICKS > 0) begin
              // Silence between notes; frequency code is held.
              w_state_nxt = S_GAP;
              w_en_nxt    = 1'b0;
            end else begin
              w_state_nxt = S_NOTE;
              w_idx_nxt   = w_idx_inc;
              w_en_nxt    = 1'b1;
              w_freq_nxt  = rom_freq(r_pocket, w_idx_inc);
            end
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            w_clr       = 1'b1;
            w_state_nxt = S_NOTE;
            w_idx_nxt   = w_idx_inc;
            w_en_nxt    = 1'b1;
            w_freq_nxt  = rom_freq(r_pocket, w_idx_inc);
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pocket <= 1'b0;
      r_idx    <= 2'd0;
      r_en     <= 1'b0;
      r_freq   <= 10'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pocket <= w_pocket_nxt;
      r_idx    <= w_idx_nxt;
      r_en     <= w_en_nxt;
      r_freq   <= w_freq_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Tick prescaler and tick counter; restart from zero on every phase change.
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_presc <= '0;
      r_tick  <= 8'd0;
    end else if (w_active) begin
      if (w_presc_end) begin
        r_presc <= '0;
        r_tick  <= r_tick + 8'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign bus.sound_enable = r_en;
  assign bus.tone_freq    = r_freq;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_sound_fx_sequencer.sv
// Bench: two sequencers (gap of 2 ticks, and no gap) driven by shared triggers,
// compared every cycle against a duration-based reference model, plus
// directed spot checks on the documented timelines.
module tb_sound_fx_sequencer;
  localparam int TC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic th  = 1'b0;
  logic tp  = 1'b0;

  always #5 clk = ~clk;

  sound_fx_if ifa();
  sound_fx_if ifb();
  assign ifa.trig_hit    = th;
  assign ifa.trig_pocket = tp;
  assign ifb.trig_hit    = th;
  assign ifb.trig_pocket = tp;

  sound_fx_sequencer #(.TICK_CYCLES(TC), .GAP_TICKS(2)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  sound_fx_sequencer #(.TICK_CYCLES(TC), .GAP_TICKS(0)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  typedef struct {
    bit active; bit pocket; bit in_gap; int idx; int remain;
    bit en; int freq; bit busy; bit done;
  } mdl_t;

  mdl_t ma, mb;
  mdl_t qa[$];
  mdl_t qb[$];
  int tests = 0;
  int fails = 0;

  function automatic int n_freq(bit p, int i);
    if (p) begin
      case (i) 0: return 784; 1: return 659; 2: return 523; default: return 392; endcase
    end
    case (i) 0: return 523; 1: return 659; default: return 784; endcase
  endfunction

  function automatic int n_ticks(bit p, int i);
    if (p) return (i == 3) ? 120 : 40;
    return (i == 2) ? 60 : 30;
  endfunction

  // One clock of the reference: phases are counted down in whole cycles.
  function automatic mdl_t step(mdl_t m, bit r, bit h, bit p, int gap);
    mdl_t n;
    n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.done = 0;
    if (p || (h && !(m.active && m.pocket))) begin
      n.active = 1; n.pocket = p; n.in_gap = 0; n.idx = 0;
      n.remain = n_ticks(p, 0) * TC;
      n.en = 1; n.freq = n_freq(p, 0); n.busy = 1;
      return n;
    end
    if (m.active) begin
      n.remain = m.remain - 1;
      if (n.remain == 0) begin
        if (m.in_gap) begin
          n.in_gap = 0; n.idx = m.idx + 1;
          n.remain = n_ticks(m.pocket, n.idx) * TC;
          n.en = 1; n.freq = n_freq(m.pocket, n.idx);
        end else if (m.idx == (m.pocket ? 3 : 2)) begin
          n.active = 0; n.en = 0; n.busy = 0; n.done = 1;
        end else if (gap > 0) begin
          n.in_gap = 1; n.remain = gap * TC; n.en = 0;
        end else begin
          n.idx = m.idx + 1;
          n.remain = n_ticks(m.pocket, n.idx) * TC;
          n.freq = n_freq(m.pocket, n.idx);
        end
      end
    end
    return n;
  endfunction

  function automatic int pk(bit b, bit d, bit e, int f);
    return (int'(b) << 12) | (int'(d) << 11) | (int'(e) << 10) | f;
  endfunction

  function automatic int obs_a();
    return pk(ifa.busy, ifa.done, ifa.sound_enable, int'(ifa.tone_freq));
  endfunction

  function automatic int obs_b();
    return pk(ifb.busy, ifb.done, ifb.sound_enable, int'(ifb.tone_freq));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got busy/done/en/freq=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               nm, (act >> 12) & 1, (act >> 11) & 1, (act >> 10) & 1, act & 1023,
               (exp >> 12) & 1, (exp >> 11) & 1, (exp >> 10) & 1, exp & 1023);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: expected outputs after each edge go into the scoreboard.
  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
  end
  always @(posedge clk) begin
    ma = step(ma, rst, th, tp, 2);
    mb = step(mb, rst, th, tp, 0);
    qa.push_back(ma);
    qb.push_back(mb);
  end

  // Monitor: pop and compare once per cycle, away from the active edge.
  always @(negedge clk) begin
    mdl_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("sb_gap2", obs_a(), pk(e.busy, e.done, e.en, e.freq));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("sb_gap0", obs_b(), pk(e.busy, e.done, e.en, e.freq));
    end
  end

  // Drive a one-cycle trigger; returns just after the sampling edge (cycle 0 end).
  task automatic pulse(input bit h, input bit p);
    @(posedge clk); #1;
    th = h; tp = p;
    @(posedge clk); #1;
    th = 1'b0; tp = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int ena_b, busy_a, busy_b, done_a, done_b;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_a", obs_a(), pk(0, 0, 0, 0));
    chk("reset_b", obs_b(), pk(0, 0, 0, 0));

    // Hit effect timeline.
    pulse(1, 0);
    ena_b = 0;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk);
      if (ifb.sound_enable) ena_b++;
      case (k)
        1:   chk("hit_n0_first", obs_a(), pk(1, 0, 1, 523));
        120: chk("hit_n0_last",  obs_a(), pk(1, 0, 1, 523));
        121: chk("hit_gap0_first", obs_a(), pk(1, 0, 0, 523));
        128: chk("hit_gap0_last",  obs_a(), pk(1, 0, 0, 523));
        129: chk("hit_n1_first", obs_a(), pk(1, 0, 1, 659));
        249: chk("hit_gap1", obs_a(), pk(1, 0, 0, 659));
        257: chk("hit_n2_first", obs_a(), pk(1, 0, 1, 784));
        496: chk("hit_n2_last", obs_a(), pk(1, 0, 1, 784));
        497: begin
          chk("hit_done", obs_a(), pk(0, 1, 0, 784));
          chk("hit_nogap_mid", 0, 0 + (ena_b == 480 ? 0 : 1));
        end
        498: chk("hit_done_drop", obs_a(), pk(0, 0, 0, 784));
        default: ;
      endcase
      if (k == 121) chk("nogap_n1", obs_b(), pk(1, 0, 1, 659));
      if (k == 481) chk("nogap_done", obs_b(), pk(0, 1, 0, 784));
    end
    chk_n("nogap_enable_cycles", ena_b, 480);
    idle(10);

    // Both triggers together -> pocket; a later hit is ignored.
    pulse(1, 1);
    busy_a = 0; busy_b = 0; done_a = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 50) th = 1'b1;
      if (k == 51) th = 1'b0;
      if (ifa.busy) busy_a++;
      if (ifb.busy) busy_b++;
      if (ifa.done) done_a++;
      if (k == 1)   chk("pocket_first", obs_a(), pk(1, 0, 1, 784));
      if (k == 52)  chk("pocket_hit_ignored", obs_a(), pk(1, 0, 1, 784));
      if (k == 161) chk("pocket_gap0", obs_a(), pk(1, 0, 0, 784));
      if (k == 169) chk("pocket_n1", obs_a(), pk(1, 0, 1, 659));
      if (k == 505) chk("pocket_n3", obs_a(), pk(1, 0, 1, 392));
      if (k == 985) chk("pocket_done", obs_a(), pk(0, 1, 0, 392));
    end
    chk_n("pocket_busy_cycles", busy_a, 984);
    chk_n("pocket_nogap_busy_cycles", busy_b, 960);
    chk_n("pocket_done_count", done_a, 1);
    idle(10);

    // Pocket preempts a running hit.
    pulse(1, 0);
    done_a = 0; done_b = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (k == 130) tp = 1'b1;
      if (k == 131) tp = 1'b0;
      if (ifa.done) done_a++;
      if (ifb.done) done_b++;
      if (k == 131)  chk("preempt_pocket", obs_a(), pk(1, 0, 1, 784));
      if (k == 1115) chk("preempt_done", obs_a(), pk(0, 1, 0, 392));
    end
    chk_n("preempt_done_count_a", done_a, 1);
    chk_n("preempt_done_count_b", done_b, 1);
    idle(10);

    // Hit restarts a running hit with cleared counters.
    pulse(1, 0);
    done_a = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (k == 60) th = 1'b1;
      if (k == 61) th = 1'b0;
      if (ifa.done) done_a++;
      if (k == 61)  chk("restart_first", obs_a(), pk(1, 0, 1, 523));
      if (k == 180) chk("restart_n0_last", obs_a(), pk(1, 0, 1, 523));
      if (k == 181) chk("restart_gap", obs_a(), pk(1, 0, 0, 523));
      if (k == 557) chk("restart_done", obs_a(), pk(0, 1, 0, 784));
    end
    chk_n("restart_done_count", done_a, 1);
    idle(10);

    // Reset mid-effect aborts without done.
    pulse(1, 0);
    done_a = 0; done_b = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (ifa.done) done_a++;
      if (ifb.done) done_b++;
      if (k == 199) chk("abort_pre", obs_b(), pk(1, 0, 1, 659));
      if (k == 200) rst = 1'b1;
      if (k == 201) begin
        rst = 1'b0;
        chk("abort_a", obs_a(), pk(0, 0, 0, 0));
        chk("abort_b", obs_b(), pk(0, 0, 0, 0));
      end
    end
    chk_n("abort_done_a", done_a, 0);
    chk_n("abort_done_b", done_b, 0);

    // Random triggers and occasional resets; scoreboard does the checking.
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      th  = ($urandom_range(0, 99) < 2);
      tp  = ($urandom_range(0, 249) == 0);
      rst = ($urandom_range(0, 1999) == 0);
    end
    th = 1'b0; tp = 1'b0; rst = 1'b0;
    idle(1100);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
